// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: the 2-bit state
// encoding and the master index constants used by the picker and the top.
package wb_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE  = 2'b00;
    localparam arb_state_t ARB_GNT_I = 2'b01;
    localparam arb_state_t ARB_GNT_D = 2'b10;

    localparam logic MASTER_INST = 1'b0;
    localparam logic MASTER_DATA = 1'b1;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
// Build option WB_ARB_RR_EN: when defined, a tie goes to the master that was
// not granted last; otherwise the data master always wins a tie.
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic i_inst_cyc,
    input  logic i_data_cyc,
`ifdef WB_ARB_RR_EN
    input  logic i_last_grant,
`endif
    output logic o_any_req,
    output logic o_winner
);

    // Pick the winning master index from the current requests
    always_comb begin
        o_any_req = i_inst_cyc | i_data_cyc;
`ifdef WB_ARB_RR_EN
        if (i_inst_cyc && i_data_cyc) begin
            o_winner = (i_last_grant == MASTER_INST) ? MASTER_DATA : MASTER_INST;
        end else begin
            o_winner = i_data_cyc ? MASTER_DATA : MASTER_INST;
        end
`else
        o_winner = i_data_cyc ? MASTER_DATA : MASTER_INST;
`endif
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter merging the instruction and data ports
// onto one shared RAM port. Grants are registered, held for the whole bus
// cycle and always released through an IDLE cycle.
// Build option WB_ARB_RR_EN: round-robin tie-break instead of data-first.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   i_inst_addr,
    input  logic [DW-1:0]   i_inst_wdata,
    input  logic [DW/8-1:0] i_inst_sel,
    input  logic            i_inst_we,
    input  logic            i_inst_cyc,
    input  logic            i_inst_stb,
    output logic [DW-1:0]   o_inst_rdata,
    output logic            o_inst_ack,

    input  logic [AW-1:0]   i_data_addr,
    input  logic [DW-1:0]   i_data_wdata,
    input  logic [DW/8-1:0] i_data_sel,
    input  logic            i_data_we,
    input  logic            i_data_cyc,
    input  logic            i_data_stb,
    output logic [DW-1:0]   o_data_rdata,
    output logic            o_data_ack,

    output logic [AW-1:0]   o_ram_addr,
    output logic [DW-1:0]   o_ram_wdata,
    output logic [DW/8-1:0] o_ram_sel,
    output logic            o_ram_we,
    output logic            o_ram_cyc,
    output logic            o_ram_stb,
    input  logic [DW-1:0]   i_ram_rdata,
    input  logic            i_ram_ack
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       w_any_req;
    logic       w_winner;

`ifdef WB_ARB_RR_EN
    logic       r_last_grant;
`endif

    wb_arb_pick u_pick (
        .i_inst_cyc   (i_inst_cyc),
        .i_data_cyc   (i_data_cyc),
`ifdef WB_ARB_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_any_req    (w_any_req),
        .o_winner     (w_winner)
    );

    // Grant state transitions: arbitrate only from IDLE, release on cyc low
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_next_state = (w_winner == MASTER_DATA) ? ARB_GNT_D : ARB_GNT_I;
                end
            end
            ARB_GNT_I: begin
                if (!i_inst_cyc) begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_GNT_D: begin
                if (!i_data_cyc) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Grant register with synchronous reset back to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef WB_ARB_RR_EN
    // Remember who won the last arbitration so the other one wins the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= MASTER_INST;
        end else if ((r_state == ARB_IDLE) && w_any_req) begin
            r_last_grant <= w_winner;
        end
    end
`endif

    // Route the granted master's request to the RAM; drive zeros while idle
    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_sel   = '0;
        o_ram_we    = 1'b0;
        o_ram_cyc   = 1'b0;
        o_ram_stb   = 1'b0;
        case (r_state)
            ARB_GNT_I: begin
                o_ram_addr  = i_inst_addr;
                o_ram_wdata = i_inst_wdata;
                o_ram_sel   = i_inst_sel;
                o_ram_we    = i_inst_we;
                o_ram_cyc   = i_inst_cyc;
                o_ram_stb   = i_inst_stb;
            end
            ARB_GNT_D: begin
                o_ram_addr  = i_data_addr;
                o_ram_wdata = i_data_wdata;
                o_ram_sel   = i_data_sel;
                o_ram_we    = i_data_we;
                o_ram_cyc   = i_data_cyc;
                o_ram_stb   = i_data_stb;
            end
            default: begin
            end
        endcase
    end

    // Read data goes to both masters; ack only to the owner, dropped in IDLE
    always_comb begin
        o_inst_rdata = i_ram_rdata;
        o_data_rdata = i_ram_rdata;
        o_inst_ack   = i_ram_ack & (r_state == ARB_GNT_I);
        o_data_ack   = i_ram_ack & (r_state == ARB_GNT_D);
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: a directed vector table, a couple of
// hand-written multi-cycle sequences, then randomized traffic compared to an
// ownership model. Honours WB_ARB_RR_EN for tie-break expectations.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] instAddr, instWdata, dataAddr, dataWdata;
    logic [3:0]  instSel, dataSel;
    logic        instWe, instCyc, instStb, dataWe, dataCyc, dataStb;
    logic [31:0] instRdata, dataRdata;
    logic        instAck, dataAck;

    logic [31:0] ramAddr, ramWdata, ramRdata;
    logic [3:0]  ramSel;
    logic        ramWe, ramCyc, ramStb, ramAck;

    int compared   = 0;
    int mismatched = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_inst_addr  (instAddr),
        .i_inst_wdata (instWdata),
        .i_inst_sel   (instSel),
        .i_inst_we    (instWe),
        .i_inst_cyc   (instCyc),
        .i_inst_stb   (instStb),
        .o_inst_rdata (instRdata),
        .o_inst_ack   (instAck),
        .i_data_addr  (dataAddr),
        .i_data_wdata (dataWdata),
        .i_data_sel   (dataSel),
        .i_data_we    (dataWe),
        .i_data_cyc   (dataCyc),
        .i_data_stb   (dataStb),
        .o_data_rdata (dataRdata),
        .o_data_ack   (dataAck),
        .o_ram_addr   (ramAddr),
        .o_ram_wdata  (ramWdata),
        .o_ram_sel    (ramSel),
        .o_ram_we     (ramWe),
        .o_ram_cyc    (ramCyc),
        .o_ram_stb    (ramStb),
        .i_ram_rdata  (ramRdata),
        .i_ram_ack    (ramAck)
    );

    typedef struct {
        logic        rst;
        logic        iCyc;
        logic        iStb;
        logic        dCyc;
        logic        dStb;
        logic        ack;
        logic        expCyc;
        logic        expStb;
        logic [31:0] expAddr;
        logic        expIAck;
        logic        expDAck;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic rst, logic iC, logic iS, logic dC, logic dS, logic ack,
                                logic eC, logic eS, logic [31:0] eA, logic eI, logic eD);
        vec_t v;
        v.rst = rst; v.iCyc = iC; v.iStb = iS; v.dCyc = dC; v.dStb = dS; v.ack = ack;
        v.expCyc = eC; v.expStb = eS; v.expAddr = eA; v.expIAck = eI; v.expDAck = eD;
        return v;
    endfunction

    // Compare one observed value with its expected value and count the result
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the control inputs of one vector row
    task automatic applyStimulus(input vec_t v);
        reset   = v.rst;
        instCyc = v.iCyc;
        instStb = v.iStb;
        dataCyc = v.dCyc;
        dataStb = v.dStb;
        ramAck  = v.ack;
    endtask

    // Advance to the next cycle: let the active edge pass, then step off it
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Ownership model: 0 = nobody, 1 = instruction, 2 = data
    int owner;
    int lastWinner;

    function automatic int tieWinner(int last);
`ifdef WB_ARB_RR_EN
        return (last == 2) ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    task automatic modelEdge();
        int w;
        if (reset) begin
            owner      = 0;
            lastWinner = 1;
        end else if (owner == 0) begin
            if (instCyc || dataCyc) begin
                if (instCyc && dataCyc) w = tieWinner(lastWinner);
                else                    w = dataCyc ? 2 : 1;
                owner      = w;
                lastWinner = w;
            end
        end else if (owner == 1 && !instCyc) begin
            owner = 0;
        end else if (owner == 2 && !dataCyc) begin
            owner = 0;
        end
    endtask

    initial begin
        logic [31:0] eAddr, eWdata;
        logic [3:0]  eSel;
        logic        eWe, eCyc, eStb;
        int          expOrder[4];
        string       tag;

        reset = 1'b1;
        instAddr = 32'h100; instWdata = 32'h1111_0000; instSel = 4'hF; instWe = 1'b0;
        dataAddr = 32'h200; dataWdata = 32'h2222_0000; dataSel = 4'hF; dataWe = 1'b0;
        instCyc = 1'b0; instStb = 1'b0; dataCyc = 1'b0; dataStb = 1'b0;
        ramAck = 1'b0; ramRdata = 32'h0;
        nextCycle();

        // Directed table; each row describes one clock cycle
        vecs[0]  = mk(1, 0,0,0,0,0, 0,0,32'h000,0,0);
        vecs[1]  = mk(0, 0,0,0,0,0, 0,0,32'h000,0,0);
        vecs[2]  = mk(0, 1,1,0,0,0, 0,0,32'h000,0,0);
        vecs[3]  = mk(0, 1,1,0,0,0, 1,1,32'h100,0,0);
        vecs[4]  = mk(0, 1,1,0,0,1, 1,1,32'h100,1,0);
        vecs[5]  = mk(0, 0,0,0,0,0, 0,0,32'h100,0,0);
        vecs[6]  = mk(0, 1,1,1,1,1, 0,0,32'h000,0,0);
        vecs[7]  = mk(0, 1,1,1,1,1, 1,1,32'h200,0,1);
        vecs[8]  = mk(0, 1,1,0,0,0, 0,0,32'h200,0,0);
        vecs[9]  = mk(0, 1,1,0,0,0, 0,0,32'h000,0,0);
        vecs[10] = mk(0, 1,1,0,0,0, 1,1,32'h100,0,0);
        vecs[11] = mk(0, 0,0,0,0,0, 0,0,32'h100,0,0);
        vecs[12] = mk(0, 0,0,0,0,0, 0,0,32'h000,0,0);
        vecs[13] = mk(0, 1,1,0,0,0, 0,0,32'h000,0,0);
        vecs[14] = mk(1, 1,1,0,0,0, 1,1,32'h100,0,0);
        vecs[15] = mk(0, 1,1,0,0,1, 0,0,32'h000,0,0);
        vecs[16] = mk(0, 0,0,0,0,0, 0,0,32'h100,0,0);
        vecs[17] = mk(0, 0,0,1,0,0, 0,0,32'h000,0,0);
        vecs[18] = mk(0, 0,0,0,0,0, 0,0,32'h200,0,0);
        vecs[19] = mk(0, 0,0,0,0,0, 0,0,32'h000,0,0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            ramRdata = $urandom;
            @(negedge clk);
            tag = $sformatf("vec%0d", i);
            checkOutput({tag, ".ram_cyc"},  32'(ramCyc),  32'(vecs[i].expCyc));
            checkOutput({tag, ".ram_stb"},  32'(ramStb),  32'(vecs[i].expStb));
            checkOutput({tag, ".ram_addr"}, ramAddr,      vecs[i].expAddr);
            checkOutput({tag, ".inst_ack"}, 32'(instAck), 32'(vecs[i].expIAck));
            checkOutput({tag, ".data_ack"}, 32'(dataAck), 32'(vecs[i].expDAck));
            checkOutput({tag, ".inst_rdata"}, instRdata, ramRdata);
            checkOutput({tag, ".data_rdata"}, dataRdata, ramRdata);
            nextCycle();
        end

        // Data-master write: request in IDLE, check the routed write while granted
        dataAddr = 32'h300; dataWdata = 32'hDEADBEEF; dataSel = 4'b0011; dataWe = 1'b1;
        dataCyc = 1'b1; dataStb = 1'b1; ramAck = 1'b0; ramRdata = 32'h1234_5678;
        nextCycle();
        ramAck = 1'b1;
        @(negedge clk);
        checkOutput("wr.ram_we",    32'(ramWe),   32'd1);
        checkOutput("wr.ram_wdata", ramWdata,     32'hDEADBEEF);
        checkOutput("wr.ram_sel",   32'(ramSel),  32'h3);
        checkOutput("wr.ram_addr",  ramAddr,      32'h300);
        checkOutput("wr.data_ack",  32'(dataAck), 32'd1);
        checkOutput("wr.inst_ack",  32'(instAck), 32'd0);
        checkOutput("wr.inst_rdata", instRdata,   32'h1234_5678);
        nextCycle();
        dataCyc = 1'b0; dataStb = 1'b0; dataWe = 1'b0; ramAck = 1'b0;
        nextCycle();

        // Continuous requests from both masters: order of four grants
`ifdef WB_ARB_RR_EN
        expOrder = '{2, 1, 2, 1};
`else
        expOrder = '{2, 2, 2, 2};
`endif
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        instAddr = 32'h100; dataAddr = 32'h200;
        for (int t = 0; t < 4; t++) begin
            instCyc = 1'b1; instStb = 1'b1; dataCyc = 1'b1; dataStb = 1'b1;
            nextCycle();
            @(negedge clk);
            checkOutput($sformatf("tie%0d.ram_cyc", t), 32'(ramCyc), 32'd1);
            checkOutput($sformatf("tie%0d.ram_addr", t), ramAddr,
                        (expOrder[t] == 2) ? 32'h200 : 32'h100);
            nextCycle();
            if (ramAddr == 32'h200) begin dataCyc = 1'b0; dataStb = 1'b0; end
            else                    begin instCyc = 1'b0; instStb = 1'b0; end
            nextCycle();
        end

        // Randomized traffic against the ownership model
        instCyc = 1'b0; instStb = 1'b0; dataCyc = 1'b0; dataStb = 1'b0; ramAck = 1'b0;
        reset = 1'b1;
        nextCycle();
        owner = 0;
        lastWinner = 1;
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 39) == 0);
            instCyc   = ($urandom_range(0, 9) < 6);
            instStb   = instCyc & ($urandom_range(0, 3) != 0);
            dataCyc   = ($urandom_range(0, 9) < 6);
            dataStb   = dataCyc & ($urandom_range(0, 3) != 0);
            instAddr  = $urandom;  dataAddr  = $urandom;
            instWdata = $urandom;  dataWdata = $urandom;
            instSel   = 4'($urandom); dataSel = 4'($urandom);
            instWe    = 1'($urandom); dataWe  = 1'($urandom);
            ramAck    = 1'($urandom);
            ramRdata  = $urandom;
            @(negedge clk);
            eAddr = 32'h0; eWdata = 32'h0; eSel = 4'h0; eWe = 1'b0; eCyc = 1'b0; eStb = 1'b0;
            if (owner == 1) begin
                eAddr = instAddr; eWdata = instWdata; eSel = instSel;
                eWe = instWe; eCyc = instCyc; eStb = instStb;
            end else if (owner == 2) begin
                eAddr = dataAddr; eWdata = dataWdata; eSel = dataSel;
                eWe = dataWe; eCyc = dataCyc; eStb = dataStb;
            end
            checkOutput("rnd.ram_addr",  ramAddr,        eAddr);
            checkOutput("rnd.ram_wdata", ramWdata,       eWdata);
            checkOutput("rnd.ram_sel",   32'(ramSel),    32'(eSel));
            checkOutput("rnd.ram_ctl",   32'({ramWe, ramCyc, ramStb}), 32'({eWe, eCyc, eStb}));
            checkOutput("rnd.inst_ack",  32'(instAck),   32'(ramAck && owner == 1));
            checkOutput("rnd.data_ack",  32'(dataAck),   32'(ramAck && owner == 2));
            checkOutput("rnd.rdata",     32'(instRdata == ramRdata && dataRdata == ramRdata), 32'd1);
            @(posedge clk);
            modelEdge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
